// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and arbiter state type shared by the ALU sharing logic
package alu_pkg;

  localparam logic [2:0] AND      = 3'b000;
  localparam logic [2:0] OR       = 3'b001;
  localparam logic [2:0] ADD      = 3'b010;
  localparam logic [2:0] NOTUSED1 = 3'b011;
  localparam logic [2:0] NOTUSED2 = 3'b100;
  localparam logic [2:0] MUL      = 3'b101;
  localparam logic [2:0] SUB      = 3'b110;
  localparam logic [2:0] SLT      = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant; search starts just after ptr
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // off = N wraps back to ptr itself, so the last winner is considered last
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - time-shares one combinational ALU between NUM_REQ requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NUM_REQ    = 2,
  parameter  int MUL_CYCLES = 2,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_src_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_src_b,
  input  logic [NUM_REQ*3-1:0]   req_alu_control,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_zero_flag,
  output logic [WIDTH-1:0]       alu_src_a,
  output logic [WIDTH-1:0]       alu_src_b,
  output logic [2:0]             alu_control,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero_flag
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  arb_state_t       state, next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   lat_id;
  logic [CW-1:0]    exec_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [WIDTH-1:0] win_a, win_b;
  logic [2:0]       win_ctl;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // grant only exists in IDLE and only for a valid requester, so it is the handshake
  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_ctl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_a   = req_src_a[i*WIDTH +: WIDTH];
        win_b   = req_src_b[i*WIDTH +: WIDTH];
        win_ctl = req_alu_control[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    if (exec_cnt == '0) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= IDW'(NUM_REQ - 1);
      lat_id         <= '0;
      exec_cnt       <= '0;
      alu_src_a      <= '0;
      alu_src_b      <= '0;
      alu_control    <= NOTUSED1;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_result    <= '0;
      resp_zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_src_a   <= win_a;
            alu_src_b   <= win_b;
            alu_control <= win_ctl;
            lat_id      <= grant_idx;
            rr_ptr      <= grant_idx;
            exec_cnt    <= (win_ctl == MUL) ? CW'(MUL_CYCLES - 1) : '0;
          end
        end
        EXEC: begin
          if (exec_cnt == '0) begin
            resp_result    <= alu_result;
            resp_zero_flag <= alu_zero_flag;
            resp_id        <= lat_id;
            resp_valid     <= 1'b1;
          end else begin
            exec_cnt <= exec_cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench with a behavioural ALU attached
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_src_a;
  logic [NREQ*WIDTH-1:0] req_src_b;
  logic [NREQ*3-1:0]     req_alu_control;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_result;
  logic                  resp_zero_flag;
  logic [WIDTH-1:0]      alu_src_a;
  logic [WIDTH-1:0]      alu_src_b;
  logic [2:0]            alu_control;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero_flag;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .MUL_CYCLES(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_src_a       (req_src_a),
    .req_src_b       (req_src_b),
    .req_alu_control (req_alu_control),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_result     (resp_result),
    .resp_zero_flag  (resp_zero_flag),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .alu_control     (alu_control),
    .alu_result      (alu_result),
    .alu_zero_flag   (alu_zero_flag)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_src_a & alu_src_b;
      3'b001:  alu_result = alu_src_a | alu_src_b;
      3'b010:  alu_result = alu_src_a + alu_src_b;
      3'b101:  alu_result = alu_src_a * alu_src_b;
      3'b110:  alu_result = alu_src_a - alu_src_b;
      3'b111:  alu_result = ($signed(alu_src_a) < $signed(alu_src_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero_flag = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    req_src_a[i*WIDTH +: WIDTH]  = a;
    req_src_b[i*WIDTH +: WIDTH]  = b;
    req_alu_control[i*3 +: 3]    = ctl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = '0;
    req_src_a       = '0;
    req_src_b       = '0;
    req_alu_control = '0;
    resp_ready      = 1'b0;
    step();
    step();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_id", resp_id, 1'b0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_resp_zero", resp_zero_flag, 1'b0);
    check("rst_alu_a", alu_src_a, 32'd0);
    check("rst_alu_b", alu_src_b, 32'd0);
    check("rst_alu_ctl", alu_control, 3'b011);
    reset = 1'b0;
    step();

    // single ADD from requester 0
    set_req(0, 3'b010, 32'd5, 32'd7);
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    #1;
    check("add_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    check("add_exec_ready", req_ready, 2'b00);
    check("add_exec_valid", resp_valid, 1'b0);
    check("add_exec_a", alu_src_a, 32'd5);
    check("add_exec_b", alu_src_b, 32'd7);
    check("add_exec_ctl", alu_control, 3'b010);
    step();
    check("add_valid", resp_valid, 1'b1);
    check("add_id", resp_id, 1'b0);
    check("add_result", resp_result, 32'd12);
    check("add_zero", resp_zero_flag, 1'b0);
    step();
    check("add_done", resp_valid, 1'b0);

    // contention: both requesters held valid, grants must alternate from 0
    do_reset();
    set_req(0, 3'b110, 32'd9, 32'd9);
    set_req(1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      check("cont_grant", req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
      step();
      step();
      check("cont_valid", resp_valid, 1'b1);
      check("cont_id", resp_id, (n % 2 == 0) ? 1'b0 : 1'b1);
      check("cont_result", resp_result, (n % 2 == 0) ? 32'd0 : 32'h0000_00FF);
      check("cont_zero", resp_zero_flag, (n % 2 == 0) ? 1'b1 : 1'b0);
      step();
    end
    req_valid = 2'b00;

    // MUL holds the ALU inputs for three execute cycles
    do_reset();
    set_req(1, 3'b101, 32'd6, 32'd7);
    req_valid = 2'b10;
    #1;
    check("mul_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      check("mul_exec_valid", resp_valid, 1'b0);
      check("mul_exec_a", alu_src_a, 32'd6);
      check("mul_exec_b", alu_src_b, 32'd7);
      check("mul_exec_ctl", alu_control, 3'b101);
      step();
    end
    check("mul_valid", resp_valid, 1'b1);
    check("mul_result", resp_result, 32'd42);
    check("mul_id", resp_id, 1'b1);
    step();

    // backpressure with a pending request from requester 0
    resp_ready = 1'b0;
    set_req(0, 3'b010, 32'd1, 32'd2);
    req_valid = 2'b01;
    #1;
    check("bp_grant", req_ready, 2'b01);
    step();
    step();
    check("bp_valid", resp_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_valid", resp_valid, 1'b1);
      check("bp_hold_result", resp_result, 32'd3);
      check("bp_hold_id", resp_id, 1'b0);
      check("bp_hold_ready", req_ready, 2'b00);
    end
    resp_ready = 1'b1;
    step();
    check("bp_release_valid", resp_valid, 1'b0);
    check("bp_regrant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    check("bp2_valid", resp_valid, 1'b1);
    check("bp2_result", resp_result, 32'd3);
    step();

    // reset in the middle of a MUL drops it
    set_req(1, 3'b101, 32'd6, 32'd7);
    req_valid = 2'b10;
    #1;
    check("rmid_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    #1;
    reset = 1'b1;
    #1;
    check("rmid_valid", resp_valid, 1'b0);
    check("rmid_ctl", alu_control, 3'b011);
    check("rmid_a", alu_src_a, 32'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rmid_no_resp", resp_valid, 1'b0);
    end
    set_req(0, 3'b000, 32'h0000_000C, 32'h0000_000A);
    set_req(1, 3'b000, 32'h0000_000C, 32'h0000_000A);
    req_valid = 2'b11;
    #1;
    check("rmid_first_prio", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    check("rmid_and_valid", resp_valid, 1'b1);
    check("rmid_and_id", resp_id, 1'b0);
    check("rmid_and_result", resp_result, 32'd8);
    step();

    // unused opcode passes through with one execute cycle
    set_req(0, 3'b100, 32'd3, 32'd4);
    req_valid = 2'b01;
    #1;
    check("unused_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    check("unused_ctl", alu_control, 3'b100);
    check("unused_exec_valid", resp_valid, 1'b0);
    step();
    check("unused_valid", resp_valid, 1'b1);
    check("unused_result", resp_result, 32'd0);
    check("unused_zero", resp_zero_flag, 1'b1);
    step();
    check("unused_done", resp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
